arbitro_memoria: RTL

ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

---
 rtl/arbitro_memoria_pkg.sv | 22 ++
 rtl/arbitro_memoria_selector_rr.sv | 28 ++
 rtl/arbitro_memoria.sv | 121 ++++++++++++
 3 files changed

// File: rtl/arbitro_memoria_pkg.sv
// ----------------------------------------------------------------------------
// arbitro_memoria_pkg: state encoding and size defaults for the arbiter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package arbitro_memoria_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 2;

  localparam logic ULTIMO_A = 1'b0;
  localparam logic ULTIMO_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESO    = 2'd1,
    RESPUESTA = 2'd2
  } estado_t;

endpackage

`default_nettype wire

// File: rtl/arbitro_memoria_selector_rr.sv
// ----------------------------------------------------------------------------
// selector_rr: two-way round-robin winner pick, one-hot result. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module selector_rr
  import arbitro_memoria_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  logic       ultimo,
  output logic [1:0] ganador
);

  always_comb begin
    ganador = 2'b00;
    if (req_a && req_b) begin
      ganador = (ultimo == ULTIMO_B) ? 2'b01 : 2'b10;
    end else if (req_a) begin
      ganador = 2'b01;
    end else if (req_b) begin
      ganador = 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/arbitro_memoria.sv
// ----------------------------------------------------------------------------
// arbitro_memoria: arbitrates two requesters onto one memory port. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module arbitro_memoria
  import arbitro_memoria_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          we_a,
  input  logic          we_b,
  input  logic [AW-1:0] dir_a,
  input  logic [AW-1:0] dir_b,
  input  logic [DW-1:0] dato_a,
  input  logic [DW-1:0] dato_b,
  output logic          ack_a,
  output logic          ack_b,
  output logic [DW-1:0] rdato_a,
  output logic [DW-1:0] rdato_b,
  output logic [1:0]    concesion,
  output logic          ocupado,
  output logic          mem_wre,
  output logic [AW-1:0] mem_dir,
  output logic [DW-1:0] mem_dato,
  input  logic [DW-1:0] mem_dsalida
);

  estado_t       estado_q;
  logic          ultimo_q;
  logic [1:0]    concesion_q;
  logic          ocupado_q;
  logic          ack_a_q;
  logic          ack_b_q;
  logic [DW-1:0] rdato_a_q;
  logic [DW-1:0] rdato_b_q;
  logic          mem_wre_q;
  logic [AW-1:0] mem_dir_q;
  logic [DW-1:0] mem_dato_q;
  logic [1:0]    ganador_d;

  selector_rr u_selector (
    .req_a   (req_a),
    .req_b   (req_b),
    .ultimo  (ultimo_q),
    .ganador (ganador_d)
  );

  // The memory-port registers double as the latched operation, so later
  // changes on we/dir/dato cannot leak into a granted transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q    <= IDLE;
      ultimo_q    <= ULTIMO_B;
      concesion_q <= 2'b00;
      ocupado_q   <= 1'b0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      rdato_a_q   <= '0;
      rdato_b_q   <= '0;
      mem_wre_q   <= 1'b0;
      mem_dir_q   <= '0;
      mem_dato_q  <= '0;
    end else begin
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      mem_wre_q <= 1'b0;
      case (estado_q)
        IDLE: begin
          if (req_a || req_b) begin
            estado_q    <= ACCESO;
            ocupado_q   <= 1'b1;
            concesion_q <= ganador_d;
            ultimo_q    <= ganador_d[1] ? ULTIMO_B : ULTIMO_A;
            mem_wre_q   <= ganador_d[1] ? we_b   : we_a;
            mem_dir_q   <= ganador_d[1] ? dir_b  : dir_a;
            mem_dato_q  <= ganador_d[1] ? dato_b : dato_a;
          end
        end
        ACCESO: begin
          estado_q <= RESPUESTA;
          if (concesion_q[1]) begin
            rdato_b_q <= mem_dsalida;
            ack_b_q   <= 1'b1;
          end else begin
            rdato_a_q <= mem_dsalida;
            ack_a_q   <= 1'b1;
          end
        end
        RESPUESTA: begin
          estado_q    <= IDLE;
          ocupado_q   <= 1'b0;
          concesion_q <= 2'b00;
        end
        default: begin
          estado_q    <= IDLE;
          ocupado_q   <= 1'b0;
          concesion_q <= 2'b00;
        end
      endcase
    end
  end

  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign rdato_a   = rdato_a_q;
  assign rdato_b   = rdato_b_q;
  assign concesion = concesion_q;
  assign ocupado   = ocupado_q;
  assign mem_wre   = mem_wre_q;
  assign mem_dir   = mem_dir_q;
  assign mem_dato  = mem_dato_q;

endmodule

`default_nettype wire
